hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, giving the maximum MD_BUSY cycles before abort (range 2..127).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports IFID_SA and IFID_TA, input, 5 each, source register addresses of the instruction in ID.
REQ-005 SHALL have ports IFID_useS and IFID_useT, input, 1 each, set when the ID instruction reads S or T.
REQ-006 SHALL have ports IDEX_MemRead (input, 1), IDEX_WB (input, 1) and IDEX_Waddr (input, 5), describing the EX-stage instruction.
REQ-007 SHALL have port branch_taken, input, 1, branch/jump resolved taken in EX.
REQ-008 SHALL have ports md_start and md_done, input, 1 each: multiply/divide issued in EX, and result ready.
REQ-009 SHALL have ports PC_en, IFID_en and IDEX_en, output, 1 each, pipeline register write enables.
REQ-010 SHALL have ports IFID_flush, IDEX_bubble and EXMEM_bubble, output, 1 each, which insert a NOP into the named register.
REQ-011 SHALL have port md_timeout, output, 1, a sticky error flag.
REQ-012 SHALL have port stall_cycles, output, 16, the stall cycle count (see Configuration).

Function
REQ-013 SHALL implement an FSM with two states, RUN and MD_BUSY, and a 7-bit down-counter md_cnt.
REQ-014 load_use SHALL be IDEX_MemRead & IDEX_WB & (IDEX_Waddr!=0) & ((IFID_useS & IFID_SA==IDEX_Waddr) | (IFID_useT & IFID_TA==IDEX_Waddr)).
REQ-015 In RUN with no event, outputs SHALL be: all enables 1, all flush and bubble outputs 0.
REQ-016 In RUN with branch_taken=1, outputs SHALL be IFID_flush=1 and IDEX_bubble=1, enables 1, in the same cycle; branch_taken SHALL take priority over load_use and md_start.
REQ-017 In RUN with load_use=1 and no branch, outputs SHALL be PC_en=0, IFID_en=0, IDEX_bubble=1 for exactly that cycle, with the FSM staying in RUN.
REQ-018 In RUN with md_start=1 and no branch, the FSM SHALL enter MD_BUSY on the next edge and load md_cnt=MD_TIMEOUT-1; load_use SHALL also apply in that cycle.
REQ-019 In MD_BUSY, outputs SHALL be PC_en=IFID_en=IDEX_en=0 and EXMEM_bubble=1; branch_taken, load_use and md_start SHALL be ignored.
REQ-020 In MD_BUSY with md_done=1, the FSM SHALL return to RUN on the next edge; md_done SHALL be ignored in RUN.
REQ-021 In MD_BUSY with md_done=0 and md_cnt==0, the FSM SHALL return to RUN, set md_timeout=1 (sticky until reset), and release the freeze; otherwise md_cnt SHALL decrement by 1 each cycle.
REQ-022 When md_done=1 and md_cnt==0 occur in the same cycle, md_done SHALL win and md_timeout SHALL not be set.
REQ-023 All outputs SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-024 Reset assertion SHALL immediately force state=RUN, md_cnt=0, md_timeout=0 and stall_cycles=0, independent of clk.
REQ-025 While reset is low, outputs SHALL be PC_en=IFID_en=IDEX_en=1 and IFID_flush=IDEX_bubble=EXMEM_bubble=0.
REQ-026 Reset asserted during MD_BUSY SHALL abort the operation without setting md_timeout.

Configuration
REQ-027 With macro HAZARD_STALL_CNT_EN defined, stall_cycles SHALL increment by 1 on each edge where PC_en==0, saturating at 16'hFFFF.
REQ-028 With macro HAZARD_STALL_CNT_EN undefined, stall_cycles SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-029 Load-use: IDEX_MemRead=1, IDEX_WB=1, IDEX_Waddr=8, IFID_SA=8, IFID_useS=1 -> one cycle of PC_en=0, IFID_en=0, IDEX_bubble=1, then RUN outputs; the same stimulus with IDEX_Waddr=0 or IFID_useS=0 -> no stall.
REQ-030 Branch plus load-use in the same cycle -> IFID_flush=1, IDEX_bubble=1, PC_en=1.
REQ-031 md_start pulse, then md_done asserted 5 cycles later -> freeze (PC_en=0, EXMEM_bubble=1) for 5 cycles, RUN on the 6th edge, md_timeout=0; with HAZARD_STALL_CNT_EN defined -> stall_cycles=5.
REQ-032 md_start with md_done never asserted, MD_TIMEOUT=4 -> freeze for 4 cycles, then md_timeout=1 held until reset; md_done on the 4th cycle instead -> md_timeout=0.
REQ-033 reset driven low mid-MD_BUSY, asynchronously between edges -> outputs return to RUN values before the next edge, and md_timeout=0.
REQ-034 With HAZARD_STALL_CNT_EN defined, preload via 65540 stall cycles -> stall_cycles=16'hFFFF (saturated, no wrap).

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit (load-use stall, branch flush, mul/div freeze with timeout); HAZARD_STALL_CNT_EN adds a stall-cycle counter
module hazard_ctrl #(
   parameter int MD_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  IFID_SA,
   input  logic [4:0]  IFID_TA,
   input  logic        IFID_useS,
   input  logic        IFID_useT,
   input  logic        IDEX_MemRead,
   input  logic        IDEX_WB,
   input  logic [4:0]  IDEX_Waddr,
   input  logic        branch_taken,
   input  logic        md_start,
   input  logic        md_done,
   output logic        PC_en,
   output logic        IFID_en,
   output logic        IDEX_en,
   output logic        IFID_flush,
   output logic        IDEX_bubble,
   output logic        EXMEM_bubble,
   output logic        md_timeout,
   output logic [15:0] stall_cycles
);
   typedef enum logic {RUN, MD_BUSY} state_t;
   state_t     state;
   logic [6:0] md_cnt;
   logic       load_use, run, busy, hold;
   assign load_use = IDEX_MemRead & IDEX_WB & (IDEX_Waddr != 5'd0) &
                     ((IFID_useS & (IFID_SA == IDEX_Waddr)) | (IFID_useT & (IFID_TA == IDEX_Waddr)));
   // reset gates the controls so a held reset always presents idle RUN outputs
   always_comb begin
      run          = reset && (state == RUN);
      busy         = reset && (state == MD_BUSY);
      hold         = busy || (run && !branch_taken && load_use);
      PC_en        = !hold;
      IFID_en      = !hold;
      IDEX_en      = !busy;
      IFID_flush   = run && branch_taken;
      IDEX_bubble  = run && (branch_taken || load_use);
      EXMEM_bubble = busy;
   end
   // FSM: freeze while a mul/div runs; md_done beats the timeout when both land together
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         md_cnt     <= 7'd0;
         md_timeout <= 1'b0;
      end else if (state == RUN) begin
         if (md_start && !branch_taken) begin
            state  <= MD_BUSY;
            md_cnt <= 7'(MD_TIMEOUT - 1);
         end
      end else if (md_done) begin
         state <= RUN;
      end else if (md_cnt == 7'd0) begin
         state      <= RUN;
         md_timeout <= 1'b1;
      end else begin
         md_cnt <= md_cnt - 7'd1;
      end
   end
`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] stall_q;
   // saturating count of cycles with the PC held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_q <= 16'd0;
      else if (!PC_en && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
   end
   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks for hazard_ctrl (MD_TIMEOUT 64 and 4 instances)
module tb_hazard_ctrl;
   logic clk = 0, reset = 0;
   logic [4:0] sa = 0, ta = 0, wa = 0;
   logic use_s = 0, use_t = 0, mr = 0, wb = 0, br = 0, md_start = 0, md_done = 0;
   logic pc_a, ifid_a, idex_a, fl_a, ib_a, eb_a, to_a;
   logic pc_b, ifid_b, idex_b, fl_b, ib_b, eb_b, to_b;
   logic [15:0] sc_a, sc_b;
   int total = 0, passed = 0;
   wire [5:0] out_a = {pc_a, ifid_a, idex_a, fl_a, ib_a, eb_a};
   wire [5:0] out_b = {pc_b, ifid_b, idex_b, fl_b, ib_b, eb_b};
   localparam logic [5:0] IDLE = 6'b111000, LU = 6'b001010, BR = 6'b111110, FRZ = 6'b000001;
`ifdef HAZARD_STALL_CNT_EN
   localparam logic [15:0] MD_STALL = 16'd5;
`else
   localparam logic [15:0] MD_STALL = 16'd0;
`endif

   always #5 clk = ~clk;

   hazard_ctrl dut_a (.clk(clk), .reset(reset), .IFID_SA(sa), .IFID_TA(ta), .IFID_useS(use_s),
      .IFID_useT(use_t), .IDEX_MemRead(mr), .IDEX_WB(wb), .IDEX_Waddr(wa), .branch_taken(br),
      .md_start(md_start), .md_done(md_done), .PC_en(pc_a), .IFID_en(ifid_a), .IDEX_en(idex_a),
      .IFID_flush(fl_a), .IDEX_bubble(ib_a), .EXMEM_bubble(eb_a), .md_timeout(to_a), .stall_cycles(sc_a));
   hazard_ctrl #(.MD_TIMEOUT(4)) dut_b (.clk(clk), .reset(reset), .IFID_SA(sa), .IFID_TA(ta), .IFID_useS(use_s),
      .IFID_useT(use_t), .IDEX_MemRead(mr), .IDEX_WB(wb), .IDEX_Waddr(wa), .branch_taken(br),
      .md_start(md_start), .md_done(md_done), .PC_en(pc_b), .IFID_en(ifid_b), .IDEX_en(idex_b),
      .IFID_flush(fl_b), .IDEX_bubble(ib_b), .EXMEM_bubble(eb_b), .md_timeout(to_b), .stall_cycles(sc_b));

   typedef struct {
      logic [4:0] sa, ta;
      logic       use_s, use_t, mr, wb;
      logic [4:0] wa;
      logic       br;
      logic [5:0] exp;
   } vec_t;
   vec_t v[10];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic idle();
      sa = 0; ta = 0; wa = 0; use_s = 0; use_t = 0; mr = 0; wb = 0; br = 0; md_start = 0; md_done = 0;
   endtask

   task automatic set_lu();
      mr = 1; wb = 1; wa = 5'd8; sa = 5'd8; use_s = 1;
   endtask

   task automatic pulse_reset();
      #1 reset = 0;
      #1 reset = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      v[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, IDLE};
      v[1] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, LU};
      v[2] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, IDLE};
      v[3] = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, IDLE};
      v[4] = '{5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, LU};
      v[5] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, IDLE};
      v[6] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, IDLE};
      v[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, BR};
      v[8] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, BR};
      v[9] = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, IDLE};
      set_lu();
      #2;
      chk("rst_out", 16'(out_a), 16'(IDLE));
      chk("rst_to", 16'(to_a), 16'd0);
      chk("rst_sc", sc_a, 16'd0);
      @(negedge clk);
      idle();
      reset = 1;
      foreach (v[i]) begin
         @(negedge clk);
         sa = v[i].sa; ta = v[i].ta; use_s = v[i].use_s; use_t = v[i].use_t;
         mr = v[i].mr; wb = v[i].wb; wa = v[i].wa; br = v[i].br;
         #2 chk($sformatf("vec%0d", i), 16'(out_a), 16'(v[i].exp));
      end
      @(negedge clk);
      idle();
      pulse_reset();
      @(negedge clk);
      md_start = 1;
      #2 chk("md_start_cyc", 16'(out_a), 16'(LU & 6'b0) | 16'(IDLE));
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         idle();
         if (k == 2) begin set_lu(); br = 1; end
         if (k == 5) md_done = 1;
         #2 chk($sformatf("md_busy%0d", k), 16'(out_a), 16'(FRZ));
         chk($sformatf("to4_busy%0d", k), 16'(out_b), 16'(k <= 4 ? FRZ : IDLE));
      end
      chk("to4_set", 16'(to_b), 16'd1);
      @(negedge clk);
      idle();
      #2 chk("md_release", 16'(out_a), 16'(IDLE));
      chk("md_no_to", 16'(to_a), 16'd0);
      chk("md_stall", sc_a, MD_STALL);
      repeat (3) @(negedge clk);
      chk("to4_sticky", 16'(to_b), 16'd1);
      pulse_reset();
      chk("to4_cleared", 16'(to_b), 16'd0);
      @(negedge clk);
      md_start = 1;
      @(negedge clk);
      md_start = 0;
      repeat (3) @(negedge clk);
      md_done = 1;
      #2 chk("to4_done_last", 16'(out_b), 16'(FRZ));
      @(negedge clk);
      md_done = 0;
      #2 chk("to4_done_rel", 16'(out_b), 16'(IDLE));
      chk("to4_done_noto", 16'(to_b), 16'd0);
      @(negedge clk);
      md_start = 1;
      @(negedge clk);
      md_start = 0;
      @(negedge clk);
      #2 chk("abort_busy", 16'(out_a), 16'(FRZ));
      #1 reset = 0;
      #1 chk("abort_out", 16'(out_a), 16'(IDLE));
      chk("abort_to", 16'(to_a), 16'd0);
      @(negedge clk);
      reset = 1;
      #2 chk("abort_run", 16'(out_a), 16'(IDLE));
`ifdef HAZARD_STALL_CNT_EN
      pulse_reset();
      @(negedge clk);
      set_lu();
      repeat (65540) @(posedge clk);
      #1 chk("stall_sat", sc_a, 16'hFFFF);
      idle();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
